// File: rtl/twd_pkg.sv
// Shared types for the FFT twiddle/butterfly stage scheduler: per-block tag and FSM states.
package twd_pkg;

    localparam int FRAME_BLKS = 16;
    localparam int BLK_W      = $clog2(FRAME_BLKS);

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             eof;
        logic [BLK_W-1:0] blk;
    } twd_tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } twd_sched_st_e;

    // Builds the tag for a block entering the chain; a bubble carries an all-zero tag.
    function automatic twd_tag_t make_tag(input logic valid, input logic [BLK_W-1:0] blk);
        twd_tag_t t;
        t = '0;
        if (valid) begin
            t.valid = 1'b1;
            t.sof   = (blk == BLK_W'(0));
            t.eof   = (blk == BLK_W'(FRAME_BLKS - 1));
            t.blk   = blk;
        end else begin
            t = '0;
        end
        return t;
    endfunction

endpackage

// File: rtl/twd_tag_delay.sv
// DEPTH-deep shift register of stage tags with synchronous clear; reports any valid tag inside.
module twd_tag_delay
    import twd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     clr,
    input  twd_tag_t d,
    output twd_tag_t q,
    output logic     any_valid
);

    twd_tag_t pipe_r [DEPTH];

    // Tag shift chain; a clear wipes every slot so no stale block survives a flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) pipe_r[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe_r[i] <= '0;
        end else begin
            pipe_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    // Occupancy of this delay segment, used by the scheduler to decide when the chain is empty.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | pipe_r[i].valid;
    end

    assign q = pipe_r[DEPTH-1];

endmodule

// File: rtl/twd_stage_sched.sv
// Twiddle-chain scheduler: counts input blocks into frames, walks a tag down every stage,
// and tracks frame occupancy and completion.
module twd_stage_sched
    import twd_pkg::*;
#(
    parameter int NUM_STAGES = 9,
    parameter int STAGE_LAT  = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_valid,
    input  logic                              i_abort,
    output logic [NUM_STAGES-1:0]             o_stage_valid,
    output logic [NUM_STAGES-1:0][BLK_W-1:0]  o_stage_blk,
    output logic [NUM_STAGES-1:0][1:0]        o_stage_quad,
    output logic [NUM_STAGES-1:0]             o_stage_sof,
    output logic [NUM_STAGES-1:0]             o_stage_eof,
    output logic                              o_busy,
    output logic                              o_frame_done,
    output logic [15:0]                       o_frame_cnt
);

    logic [BLK_W-1:0]      blk_cnt_r;
    twd_sched_st_e         state_r;
    logic                  busy_r;
    logic                  done_r;
    logic [15:0]           frame_cnt_r;
    twd_tag_t              in_tag_s;
    twd_tag_t              stage_in_s  [NUM_STAGES];
    twd_tag_t              stage_tag_s [NUM_STAGES];
    logic [NUM_STAGES-1:0] stage_occ_s;
    logic                  any_valid_s;
    logic                  last_eof_s;

    assign in_tag_s    = make_tag(i_valid, blk_cnt_r);
    assign any_valid_s = |stage_occ_s;
    assign last_eof_s  = stage_tag_s[NUM_STAGES-1].valid & stage_tag_s[NUM_STAGES-1].eof;

    // Stage 0 is a single input register; every later stage adds STAGE_LAT cycles.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in_s[k] = in_tag_s;
        end else begin : g_next
            assign stage_in_s[k] = stage_tag_s[k-1];
        end

        twd_tag_delay #(
            .DEPTH ((k == 0) ? 1 : STAGE_LAT)
        ) u_dly (
            .clk       (clk),
            .rstn      (rstn),
            .clr       (i_abort),
            .d         (stage_in_s[k]),
            .q         (stage_tag_s[k]),
            .any_valid (stage_occ_s[k])
        );

        assign o_stage_valid[k] = stage_tag_s[k].valid;
        assign o_stage_blk[k]   = stage_tag_s[k].blk;
        assign o_stage_quad[k]  = stage_tag_s[k].blk[BLK_W-1 -: 2];
        assign o_stage_sof[k]   = stage_tag_s[k].sof;
        assign o_stage_eof[k]   = stage_tag_s[k].eof;
    end

    // Block index within the frame; wraps naturally because FRAME_BLKS is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_cnt_r <= '0;
        end else if (i_abort) begin
            blk_cnt_r <= '0;
        end else if (i_valid) begin
            blk_cnt_r <= blk_cnt_r + BLK_W'(1);
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    // Occupancy FSM; blk_cnt==0 in RUN means the previous block closed a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else if (i_abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    busy_r <= 1'b1;
                    if (!i_valid && (blk_cnt_r == BLK_W'(0))) state_r <= DRAIN;
                    else                                      state_r <= RUN;
                end
                DRAIN: begin
                    if (i_valid) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else if (!any_valid_s && (blk_cnt_r == BLK_W'(0))) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= DRAIN;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse and frame counter follow the eof tag leaving the last stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_r      <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else if (i_abort) begin
            done_r      <= 1'b0;
            frame_cnt_r <= frame_cnt_r;
        end else if (last_eof_s) begin
            done_r      <= 1'b1;
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            done_r      <= 1'b0;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign o_busy       = busy_r;
    assign o_frame_done = done_r;
    assign o_frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_twd_stage_sched.sv
// Directed bench for twd_stage_sched: vector table for the first frame plus multi-cycle sequences.
module tb_twd_stage_sched;
    import twd_pkg::*;

    localparam int N = 9;
    localparam int L = 2;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  i_valid = 1'b0;
    logic                  i_abort = 1'b0;
    logic [N-1:0]          o_stage_valid;
    logic [N-1:0][3:0]     o_stage_blk;
    logic [N-1:0][1:0]     o_stage_quad;
    logic [N-1:0]          o_stage_sof;
    logic [N-1:0]          o_stage_eof;
    logic                  o_busy;
    logic                  o_frame_done;
    logic [15:0]           o_frame_cnt;

    twd_stage_sched #(.NUM_STAGES(N), .STAGE_LAT(L)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_valid       (i_valid),
        .i_abort       (i_abort),
        .o_stage_valid (o_stage_valid),
        .o_stage_blk   (o_stage_blk),
        .o_stage_quad  (o_stage_quad),
        .o_stage_sof   (o_stage_sof),
        .o_stage_eof   (o_stage_eof),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_clear = 0;
    int mcnt = 0;
    logic [3:0] mblk = 4'd0;
    bit         hist_v   [0:1023];
    logic [3:0] hist_blk [0:1023];

    typedef struct {
        bit         v;
        bit         a;
        bit         ev;
        logic [3:0] eblk;
        logic [1:0] equad;
        bit         esof;
        bit         eeof;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Expected {valid,sof,eof,quad,blk} at stage k after edge c, from the accept history.
    function automatic logic [8:0] exp_tag(input int k, input int c);
        int src;
        logic [3:0] b;
        src = c - k * L;
        if (src >= 1 && src > last_clear && hist_v[src]) begin
            b = hist_blk[src];
            return {1'b1, (b == 4'd0), (b == 4'd15), b[3:2], b};
        end
        return 9'd0;
    endfunction

    task automatic model_edge(input bit v, input bit a);
        logic [8:0] e;
        cyc++;
        if (v && !a) begin
            hist_v[cyc]   = 1'b1;
            hist_blk[cyc] = mblk;
            mblk          = mblk + 4'd1;
        end else begin
            hist_v[cyc]   = 1'b0;
            hist_blk[cyc] = 4'd0;
        end
        if (a) begin
            mblk       = 4'd0;
            last_clear = cyc;
        end
        e = exp_tag(N - 1, cyc - 1);
        if (e[8] && e[6]) mcnt++;
    endtask

    task automatic check_all();
        logic [8:0] e;
        logic [8:0] act;
        for (int k = 0; k < N; k++) begin
            e   = exp_tag(k, cyc);
            act = {o_stage_valid[k], o_stage_sof[k], o_stage_eof[k], o_stage_quad[k], o_stage_blk[k]};
            chk($sformatf("stage%0d_tag", k), 32'(act), 32'(e));
        end
        e = exp_tag(N - 1, cyc - 1);
        chk("frame_done", 32'(o_frame_done), 32'(e[8] & e[6] & (last_clear != cyc)));
        chk("frame_cnt", 32'(o_frame_cnt), 32'(mcnt[15:0]));
    endtask

    task automatic step(input bit v, input bit a);
        i_valid = v;
        i_abort = a;
        @(posedge clk);
        model_edge(v, a);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, 32'(o_stage_valid), 32'd0);
        chk({name, "_blk"}, 32'(o_stage_blk), 32'd0);
        chk({name, "_flags"}, 32'({o_stage_sof, o_stage_eof, o_stage_quad}), 32'd0);
        chk({name, "_busy_done"}, 32'({o_busy, o_frame_done}), 32'd0);
        chk({name, "_cnt"}, 32'(o_frame_cnt), 32'd0);
    endtask

    // Idles for n edges and returns the edge of the first and second done pulse (0 if none).
    task automatic idle_watch(input int n, output int d1, output int d2, output int pulses);
        d1 = 0; d2 = 0; pulses = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0);
            if (o_frame_done) begin
                pulses++;
                if (d1 == 0) d1 = cyc;
                else if (d2 == 0) d2 = cyc;
            end
        end
    endtask

    initial begin
        int d1, d2, np, first8, e_last, s0, sof_a, sof_b;

        tbl[0]  = '{1, 0, 1, 4'd0,  2'd0, 1, 0};
        tbl[1]  = '{1, 0, 1, 4'd1,  2'd0, 0, 0};
        tbl[2]  = '{1, 0, 1, 4'd2,  2'd0, 0, 0};
        tbl[3]  = '{1, 0, 1, 4'd3,  2'd0, 0, 0};
        tbl[4]  = '{1, 0, 1, 4'd4,  2'd1, 0, 0};
        tbl[5]  = '{1, 0, 1, 4'd5,  2'd1, 0, 0};
        tbl[6]  = '{1, 0, 1, 4'd6,  2'd1, 0, 0};
        tbl[7]  = '{1, 0, 1, 4'd7,  2'd1, 0, 0};
        tbl[8]  = '{1, 0, 1, 4'd8,  2'd2, 0, 0};
        tbl[9]  = '{1, 0, 1, 4'd9,  2'd2, 0, 0};
        tbl[10] = '{1, 0, 1, 4'd10, 2'd2, 0, 0};
        tbl[11] = '{1, 0, 1, 4'd11, 2'd2, 0, 0};
        tbl[12] = '{1, 0, 1, 4'd12, 2'd3, 0, 0};
        tbl[13] = '{1, 0, 1, 4'd13, 2'd3, 0, 0};
        tbl[14] = '{1, 0, 1, 4'd14, 2'd3, 0, 0};
        tbl[15] = '{1, 0, 1, 4'd15, 2'd3, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;

        // Frame 1: table-driven, contiguous valids; stage 8 and done timing
        first8 = 0;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].a);
            chk($sformatf("tbl%0d_stage0", i),
                32'({o_stage_valid[0], o_stage_blk[0], o_stage_quad[0], o_stage_sof[0], o_stage_eof[0]}),
                32'({tbl[i].ev, tbl[i].eblk, tbl[i].equad, tbl[i].esof, tbl[i].eeof}));
        end
        d1 = 0; np = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0);
            if (o_stage_valid[N-1] && first8 == 0) first8 = cyc;
            if (o_frame_done) begin np++; d1 = cyc; end
            if (cyc == 33) chk("busy_at_done", 32'(o_busy), 32'd1);
            if (cyc == 34) chk("busy_after_done", 32'(o_busy), 32'd0);
        end
        chk("f1_first_stage8", 32'(first8), 32'd17);
        chk("f1_done_edge", 32'(d1), 32'd33);
        chk("f1_done_pulses", 32'(np), 32'd1);
        chk("f1_cnt", 32'(o_frame_cnt), 32'd1);

        // Frame 2: valid every other cycle
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            if (i < 15) step(1'b0, 1'b0);
        end
        e_last = cyc;
        idle_watch(22, d1, d2, np);
        chk("gap_done_edge", 32'(d1), 32'(e_last + 17));
        chk("gap_done_pulses", 32'(np), 32'd1);
        chk("gap_busy_end", 32'(o_busy), 32'd0);

        // Frames 3-4: back-to-back, no DRAIN between them
        s0 = cyc + 1; sof_a = 0; sof_b = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            if (o_stage_sof[0]) begin
                if (sof_a == 0) sof_a = cyc;
                else sof_b = cyc;
            end
            if (i > 0) chk("b2b_no_drain", 32'(dut.state_r == DRAIN), 32'd0);
        end
        chk("b2b_sof_a", 32'(sof_a), 32'(s0));
        chk("b2b_sof_b", 32'(sof_b), 32'(s0 + 16));
        idle_watch(24, d1, d2, np);
        chk("b2b_done1", 32'(d1), 32'(s0 + 15 + 17));
        chk("b2b_done2", 32'(d2), 32'(s0 + 31 + 17));
        chk("b2b_cnt", 32'(o_frame_cnt), 32'd4);

        // Abort at block 9 while i_valid is high
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("abort_valid", 32'(o_stage_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        idle_watch(24, d1, d2, np);
        chk("abort_no_done", 32'(np), 32'd0);
        chk("abort_cnt", 32'(o_frame_cnt), 32'd4);
        step(1'b1, 1'b0);
        chk("abort_restart_blk", 32'({o_stage_valid[0], o_stage_sof[0], o_stage_blk[0]}), 32'({1'b1, 1'b1, 4'd0}));
        for (int i = 1; i < 16; i++) step(1'b1, 1'b0);
        idle_watch(20, d1, d2, np);
        chk("abort_next_cnt", 32'(o_frame_cnt), 32'd5);

        // Asynchronous reset at block 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_rst");
        i_valid = 1'b0;
        i_abort = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b1);
        mcnt = 0;
        #1;
        rstn = 1'b1;
        check_all();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        idle_watch(22, d1, d2, np);
        chk("rst_frame_pulses", 32'(np), 32'd1);
        chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd1);

        // Partial frame stays pending until the 16th block arrives
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
        idle_watch(25, d1, d2, np);
        chk("partial_no_done", 32'(np), 32'd0);
        chk("partial_busy", 32'(o_busy), 32'd1);
        step(1'b1, 1'b0);
        e_last = cyc;
        idle_watch(22, d1, d2, np);
        chk("partial_done_edge", 32'(d1), 32'(e_last + 17));
        chk("partial_cnt", 32'(o_frame_cnt), 32'd2);
        chk("partial_idle", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
